// File: rtl/fpadd_seq.sv
// fpadd_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
// Define FPADD_ROUND_EN for round-to-nearest-even (default truncates).
module fpadd_seq #(
  parameter int NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, PACK, DONE
  } state_t;

`ifdef FPADD_ROUND_EN
  localparam int GW = 3;
`else
  localparam int GW = 0;
`endif
  // mantissa with hidden bit at MW-1, guard bits below
  localparam int MW = 24 + GW;
  localparam logic [4:0] STEP = 5'(NORM_STEP);

  state_t state, stateNext;

  logic              bigSign, smallSign;
  logic [MW-1:0]     bigMan, smallMan;
  logic [7:0]        expDiff;
  logic signed [9:0] expR;
  logic [MW:0]       sumMan;
  logic              resSign;
  logic              zeroR, underR;
  logic              isSpecial, specNan;
  logic [31:0]       specRes;
  logic [31:0]       resR;
  logic [3:0]        flagR;

  logic accept;
  assign in_ready   = reset_n & (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == DONE);
  assign out_result = resR;
  assign out_flags  = flagR;

  logic [7:0]    aExp, bExp;
  logic          aSign, bSign;
  logic          aNan, bNan, aInf, bInf;
  logic          specNanIn, specialIn;
  logic [31:0]   specResIn;
  logic [MW-1:0] aMan, bMan;
  logic          swap;

  always_comb begin
    aExp      = in_a[30:23];
    bExp      = in_b[30:23];
    aSign     = in_a[31];
    bSign     = in_b[31] ^ in_sub;
    aNan      = (&aExp) & (|in_a[22:0]);
    bNan      = (&bExp) & (|in_b[22:0]);
    aInf      = (&aExp) & ~(|in_a[22:0]);
    bInf      = (&bExp) & ~(|in_b[22:0]);
    specNanIn = aNan | bNan | (aInf & bInf & (aSign != bSign));
    specialIn = aNan | bNan | aInf | bInf;
    if (specNanIn)
      specResIn = 32'h7FC0_0000;
    else if (aInf)
      specResIn = {aSign, 8'hFF, 23'd0};
    else
      specResIn = {bSign, 8'hFF, 23'd0};
    // zero exponent flushes to zero: hidden bit cleared
    aMan = MW'({|aExp, in_a[22:0]}) << GW;
    bMan = MW'({|bExp, in_b[22:0]}) << GW;
    swap = bExp > aExp;
  end

  logic [MW-1:0] alignMan;
  always_comb begin
    alignMan = smallMan >> expDiff;
`ifdef FPADD_ROUND_EN
    if (expDiff >= 8'd26)
      alignMan = {{(MW-1){1'b0}}, |smallMan};
    else
      alignMan[0] = alignMan[0] |
        (|(smallMan & ~({MW{1'b1}} << expDiff)));
`else
    if (expDiff >= 8'd26)
      alignMan = '0;
`endif
  end

  logic [MW:0] sumComb;
  logic        signComb, magGe;
  always_comb begin
    magGe = bigMan >= smallMan;
    if (bigSign == smallSign) begin
      sumComb  = {1'b0, bigMan} + {1'b0, smallMan};
      signComb = bigSign;
    end else if (magGe) begin
      sumComb  = {1'b0, bigMan} - {1'b0, smallMan};
      signComb = bigSign;
    end else begin
      sumComb  = {1'b0, smallMan} - {1'b0, bigMan};
      signComb = smallSign;
    end
  end

  function automatic logic [4:0] lzCount(input logic [MW-1:0] v);
    lzCount = 5'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzCount = 5'(MW - 1 - i);
  endfunction

  logic [4:0]        lz, amt;
  logic signed [9:0] expShift;
  logic              normDone;
  always_comb begin
    lz       = lzCount(sumMan[MW-1:0]);
    amt      = (lz < STEP) ? lz : STEP;
    expShift = expR - signed'({5'd0, amt});
    // last shift lands the leading one, so finish in the same cycle
    normDone = (sumMan == '0) | sumMan[MW] | (lz == 5'd0) |
               (amt == lz) | (expShift <= 10'sd0);
  end

  logic signed [9:0] packExp;
  logic [22:0]       packFrac;
  logic [31:0]       packRes;
  logic [3:0]        packFlags;
`ifdef FPADD_ROUND_EN
  logic        roundUp;
  logic [24:0] rounded;
`endif
  always_comb begin
`ifdef FPADD_ROUND_EN
    roundUp = sumMan[2] & (sumMan[1] | sumMan[0] | sumMan[3]);
    rounded = {1'b0, sumMan[26:3]} + 25'(roundUp);
    if (rounded[24]) begin
      packExp  = expR + 10'sd1;
      packFrac = rounded[23:1];
    end else begin
      packExp  = expR;
      packFrac = rounded[22:0];
    end
`else
    packExp  = expR;
    packFrac = sumMan[22:0];
`endif
    if (isSpecial) begin
      packRes   = specRes;
      packFlags = {specNan, 3'b000};
    end else if (zeroR) begin
      packRes   = 32'd0;
      packFlags = 4'b0001;
    end else if (underR) begin
      packRes   = {resSign, 31'd0};
      packFlags = 4'b0011;
    end else if (packExp >= 10'sd255) begin
      packRes   = {resSign, 8'hFF, 23'd0};
      packFlags = 4'b0100;
    end else begin
      packRes   = {resSign, packExp[7:0], packFrac};
      packFlags = 4'b0000;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (accept) stateNext = ALIGN;
      ALIGN: stateNext = isSpecial ? PACK : ADD;
      ADD:   stateNext = NORM;
      NORM:  if (normDone) stateNext = PACK;
      PACK:  stateNext = DONE;
      DONE:  if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bigSign   <= 1'b0;
      smallSign <= 1'b0;
      bigMan    <= '0;
      smallMan  <= '0;
      expDiff   <= '0;
      expR      <= '0;
      sumMan    <= '0;
      resSign   <= 1'b0;
      zeroR     <= 1'b0;
      underR    <= 1'b0;
      isSpecial <= 1'b0;
      specNan   <= 1'b0;
      specRes   <= '0;
      resR      <= '0;
      flagR     <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          bigSign   <= swap ? bSign : aSign;
          smallSign <= swap ? aSign : bSign;
          bigMan    <= swap ? bMan : aMan;
          smallMan  <= swap ? aMan : bMan;
          expR      <= {2'b00, swap ? bExp : aExp};
          expDiff   <= swap ? bExp - aExp : aExp - bExp;
          zeroR     <= 1'b0;
          underR    <= 1'b0;
          isSpecial <= specialIn;
          specNan   <= specNanIn;
          specRes   <= specResIn;
        end
        ALIGN: smallMan <= alignMan;
        ADD: begin
          sumMan  <= sumComb;
          resSign <= signComb;
        end
        NORM: begin
          if (sumMan == '0) begin
            zeroR <= 1'b1;
          end else if (sumMan[MW]) begin
`ifdef FPADD_ROUND_EN
            sumMan <= {1'b0, sumMan[MW:2], sumMan[1] | sumMan[0]};
`else
            sumMan <= sumMan >> 1;
`endif
            expR <= expR + 10'sd1;
          end else if (lz != 5'd0) begin
            sumMan <= sumMan << amt;
            expR   <= expShift;
            if (expShift <= 10'sd0) underR <= 1'b1;
          end
        end
        PACK: begin
          resR  <= packRes;
          flagR <= packFlags;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_seq.sv
// tb_fpadd_seq: directed vectors for fpadd_seq, checked
// with immediate assertions against hand-computed results.
module tb_fpadd_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int total;
  int bad;

  fpadd_seq #(.NORM_STEP(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doOp(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic sub,
                      input logic [31:0] expRes,
                      input logic [3:0] expFlg,
                      input int expLat, input int hold);
    int lat;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'hDEAD_BEEF;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(expLat));
    chk({tag, "_res"}, out_result, expRes);
    chk({tag, "_flg"}, {28'd0, out_flags}, {28'd0, expFlg});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hv"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hr"}, out_result, expRes);
      chk({tag, "_hf"}, {28'd0, out_flags}, {28'd0, expFlg});
      chk({tag, "_hi"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_dv"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_di"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_flg", {28'd0, out_flags}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    doOp("add32", 32'h42000000, 32'h42000000, 1'b0,
         32'h42800000, 4'b0000, 4, 0);
    doOp("add5", 32'h42000000, 32'h40A00000, 1'b0,
         32'h42140000, 4'b0000, 4, 0);
    doOp("sub5", 32'h42000000, 32'h40A00000, 1'b1,
         32'h41D80000, 4'b0000, 4, 0);
    doOp("ulp", 32'h3F800001, 32'h3F800000, 1'b1,
         32'h34000000, 4'b0000, 26, 0);
    doOp("zero", 32'h42000000, 32'h42000000, 1'b1,
         32'h00000000, 4'b0001, 4, 0);
    doOp("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
         32'h7F800000, 4'b0100, 4, 0);
    doOp("nan", 32'h7FC00000, 32'h3F800000, 1'b0,
         32'h7FC00000, 4'b1000, 2, 0);
    doOp("infinf", 32'h7F800000, 32'h7F800000, 1'b1,
         32'h7FC00000, 4'b1000, 2, 0);
    doOp("oneinf", 32'h3F800000, 32'h7F800000, 1'b1,
         32'hFF800000, 4'b0000, 2, 0);
    doOp("undf", 32'h00800001, 32'h00800000, 1'b1,
         32'h00000000, 4'b0011, 4, 0);
    doOp("swap", 32'h3F800000, 32'h40000000, 1'b1,
         32'hBF800000, 4'b0000, 4, 0);
    doOp("far", 32'h4C800000, 32'h3F800000, 1'b0,
         32'h4C800000, 4'b0000, 4, 0);
    doOp("pzero", 32'h3F800000, 32'h00000000, 1'b0,
         32'h3F800000, 4'b0000, 4, 0);
    doOp("hold", 32'h42000000, 32'h42000000, 1'b0,
         32'h42800000, 4'b0000, 4, 5);

    in_a = 32'h3F800001;
    in_b = 32'h3F800000;
    in_sub = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_vld", {31'd0, out_valid}, 32'd0);
    chk("ar_rdy", {31'd0, in_ready}, 32'd0);
    chk("ar_res", out_result, 32'd0);
    chk("ar_flg", {28'd0, out_flags}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_rdy1", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1;
    end
    chk("ar_novld", 32'(seen), 32'd0);
    doOp("one1", 32'h3F800000, 32'h3F800000, 1'b0,
         32'h40000000, 4'b0000, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
